inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prefetch FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req  out  1  single-cycle pulse issuing one instruction-memory read.
REQ-006 SHALL have port imem_addr  out  32  read address, valid when imem_req=1.
REQ-007 SHALL have port imem_ack  in  1  single-cycle pulse marking read data return.
REQ-008 SHALL have port imem_rdata  in  32  read data, valid when imem_ack=1.
REQ-009 SHALL have port redirect  in  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  in  32  new fetch address, valid when redirect=1.
REQ-011 SHALL have port inst_valid  out  1  FIFO head instruction available to decode.
REQ-012 SHALL have port inst  out  32  head instruction word.
REQ-013 SHALL have port inst_pc  out  32  address of head instruction.
REQ-014 SHALL have port inst_ready  in  1  decode accepts head this cycle.

Function
REQ-015 SHALL hold registers fetch_pc (32b), FSM state, and a DEPTH-entry FIFO of {pc, word} with count 0..DEPTH.
REQ-016 SHALL implement FSM states IDLE (nothing outstanding), WAIT (one request outstanding, keep data), DROP (one request outstanding, discard data).
REQ-017 SHALL drive imem_req = (state==IDLE) & (count<DEPTH) & ~redirect & ~rst, combinationally, with imem_addr = fetch_pc.
REQ-018 SHALL transition IDLE->WAIT in every cycle imem_req=1; at most one request outstanding at any time.
REQ-019 In WAIT with imem_ack=1 and redirect=0, SHALL push {fetch_pc, imem_rdata}, set fetch_pc <= fetch_pc+4 (mod 2^32 wrap), go IDLE.
REQ-020 In WAIT or DROP with redirect=1, SHALL flush FIFO (count<=0, pointers reset), load fetch_pc <= redirect_pc, go IDLE if imem_ack=1 that cycle (data discarded), else DROP.
REQ-021 In DROP with imem_ack=1 and redirect=0, SHALL discard imem_rdata, leave fetch_pc unchanged, go IDLE.
REQ-022 In IDLE with redirect=1, SHALL flush FIFO, load fetch_pc <= redirect_pc, stay IDLE, issue no request that cycle.
REQ-023 SHALL ignore imem_ack when in IDLE.
REQ-024 SHALL drive inst_valid = (count!=0) & ~redirect, and inst/inst_pc from FIFO head (registered storage, no bypass from imem_rdata).
REQ-025 SHALL pop head when inst_valid & inst_ready; simultaneous push and pop leave count unchanged.
REQ-026 SHALL never overflow: push only follows a request issued with count<DEPTH, and count never increases between issue and ack.
REQ-027 Minimum latency: request at cycle N, ack at N+1, inst_valid at N+2; sustained throughput one instruction per two cycles.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 While rst=1, SHALL force state IDLE, fetch_pc=RESET_PC, count=0, pointers=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-030 Reset asserted mid-WAIT SHALL abandon the outstanding request; the first cycle after deassertion issues imem_req with imem_addr=RESET_PC.

Verification
REQ-031 Reset release, memory acks 1 cycle after each req, inst_ready=1 -> imem_addr 0,4,8,...; inst_pc 0,4,8 with matching words, one per 2 cycles.
REQ-032 inst_ready=0, DEPTH=4 -> exactly 4 requests (0x0-0xC), then imem_req stays 0; one pop -> next req at 0x10 the following cycle.
REQ-033 redirect=1, redirect_pc=0x100 while WAIT, ack 2 cycles later -> FIFO empty, late data dropped, next imem_addr=0x100, first inst_pc=0x100.
REQ-034 redirect coincident with imem_ack, redirect_pc=0x40 -> data discarded, state IDLE, next cycle imem_addr=0x40; inst_valid=0 in redirect cycle.
REQ-035 redirect_pc=0xFFFFFFFC -> fetched inst_pc sequence 0xFFFFFFFC, 0x00000000.
REQ-036 rst pulsed while WAIT with 2 FIFO entries -> inst_valid=0 immediately; after release imem_addr=RESET_PC; stale ack before first new req ignored.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues one instruction-memory read at a time and
// queues returned words with their addresses in a small prefetch FIFO for decode.
module inst_fetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t        state, next_state;
   logic [31:0]   fetch_pc;
   logic [AW:0]   count;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   word_mem [DEPTH];

   logic push, pop, flush;

   // A request may only go out while a FIFO slot is guaranteed for its data.
   assign imem_req  = (state == IDLE) & (count < (AW+1)'(DEPTH)) & ~redirect & ~rst;
   assign imem_addr = fetch_pc;

   assign inst_valid = (count != '0) & ~redirect;
   assign pop        = inst_valid & inst_ready;
   assign inst       = (count != '0) ? word_mem[rd_ptr] : '0;
   assign inst_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;

   // NOTE: every signal written here gets a default first, otherwise an
   // unassigned path through the case turns it into a latch.
   always_comb begin
      next_state = state;
      push       = 1'b0;
      flush      = 1'b0;
      case (state)
         IDLE: begin
            if (redirect)      flush      = 1'b1;
            else if (imem_req) next_state = WAIT;
         end
         WAIT: begin
            if (redirect) begin
               flush      = 1'b1;
               next_state = imem_ack ? IDLE : DROP;
            end else if (imem_ack) begin
               push       = 1'b1;
               next_state = IDLE;
            end
         end
         DROP: begin
            if (redirect) begin
               flush      = 1'b1;
               next_state = imem_ack ? IDLE : DROP;
            end else if (imem_ack) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state <= next_state;
         if (flush) begin
            fetch_pc <= redirect_pc;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (push) begin
               fetch_pc <= fetch_pc + 32'd4;
               wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
         end
      end
   end

   // NOTE: the storage array has no reset; outputs are gated by count, so
   // stale entries are never visible and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= fetch_pc;
         word_mem[wr_ptr] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a behavioural model and scoreboard queue track
// expected requests and delivered instructions cycle by cycle.
module tb_inst_fetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst, imem_req, imem_ack, redirect, inst_valid, inst_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

   always #5 clk = ~clk;

   inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_ready(inst_ready)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } ent_t;

   int          errors = 0;
   int          checks = 0;
   ent_t        sb[$];
   logic [31:0] popped[$];
   bit          m_out, m_drop;
   logic [31:0] m_pc;
   int          n_req, n_pop;
   int          ack_cnt = 0;
   int          ack_delay = 1;
   logic [31:0] ack_addr = '0;
   logic        last_req, last_valid;
   logic [31:0] last_addr;

   function automatic logic [31:0] word_of(logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs were set in the low phase; sample, update the
   // model with this cycle's inputs, clock, then run the memory responder.
   task automatic cyc();
      bit exp_req, exp_valid;
      #1;
      last_req   = imem_req;
      last_addr  = imem_addr;
      last_valid = inst_valid;
      if (rst) begin
         check("rst_imem_req", imem_req, 0);
         check("rst_inst_valid", inst_valid, 0);
         check("rst_inst", inst, 0);
         check("rst_inst_pc", inst_pc, 0);
         m_out  = 0;
         m_drop = 0;
         m_pc   = RESET_PC;
         sb.delete();
      end else begin
         exp_req   = !m_out && (sb.size() < DEPTH) && !redirect;
         exp_valid = (sb.size() != 0) && !redirect;
         check("imem_req", imem_req, exp_req);
         if (exp_req) check("imem_addr", imem_addr, m_pc);
         check("inst_valid", inst_valid, exp_valid);
         if (exp_valid) begin
            check("inst_pc", inst_pc, sb[0].pc);
            check("inst", inst, sb[0].word);
            if (inst_ready) begin
               popped.push_back(sb[0].pc);
               void'(sb.pop_front());
               n_pop++;
            end
         end
         if (imem_ack && m_out) begin
            if (!redirect && !m_drop) begin
               sb.push_back('{pc: m_pc, word: word_of(m_pc)});
               m_pc = m_pc + 32'd4;
            end
            m_out  = 0;
            m_drop = 0;
         end
         if (redirect) begin
            sb.delete();
            m_pc   = redirect_pc;
            m_drop = m_out;
         end
         if (exp_req) begin
            m_out    = 1;
            m_drop   = 0;
            n_req++;
            ack_cnt  = ack_delay;
            ack_addr = m_pc;
         end
      end
      @(posedge clk);
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (ack_cnt > 0) begin
         ack_cnt--;
         if (ack_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = word_of(ack_addr);
         end
      end
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      ack_cnt  = 0;
      imem_ack = 1'b0;
      redirect = 1'b0;
      rst      = 1'b1;
      run(2);
      rst   = 1'b0;
      n_req = 0;
      n_pop = 0;
      popped.delete();
   endtask

   initial begin
      rst         = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      inst_ready  = 1'b1;
      #1 rst = 1'b1;
      @(negedge clk);

      // Streaming with 1-cycle memory: one instruction per two cycles.
      do_reset();
      inst_ready = 1'b1;
      ack_delay  = 1;
      run(12);
      check("stream_reqs", n_req, 6);
      check("stream_pops", n_pop, 5);
      check("stream_pc2", popped[2], 32'h8);

      // Decode stalled: FIFO fills after four requests, one pop reopens it.
      do_reset();
      inst_ready = 1'b0;
      run(12);
      check("full_reqs", n_req, 4);
      inst_ready = 1'b1;
      cyc();
      inst_ready = 1'b0;
      cyc();
      check("refill_req", last_req, 1);
      check("refill_addr", last_addr, 32'h10);
      inst_ready = 1'b1;
      run(10);

      // Redirect while WAIT with two queued entries; the late ack is dropped.
      do_reset();
      inst_ready = 1'b0;
      run(4);
      ack_delay = 3;
      cyc();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      cyc();
      check("wait_redir_req", last_req, 0);
      redirect   = 1'b0;
      ack_delay  = 1;
      inst_ready = 1'b1;
      popped.delete();
      run(10);
      check("wait_redir_pops", popped.size() != 0, 1);
      check("wait_redir_pc", popped[0], 32'h100);

      // Redirect coincident with the ack.
      do_reset();
      cyc();
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      cyc();
      check("ack_redir_valid", last_valid, 0);
      redirect = 1'b0;
      popped.delete();
      cyc();
      check("ack_redir_req", last_req, 1);
      check("ack_redir_addr", last_addr, 32'h40);
      run(6);
      check("ack_redir_pc", popped[0], 32'h40);

      // Address wrap past the top of the address space.
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      cyc();
      redirect = 1'b0;
      popped.delete();
      run(10);
      check("wrap_pops", popped.size() >= 2, 1);
      check("wrap_pc0", popped[0], 32'hFFFF_FFFC);
      check("wrap_pc1", popped[1], 32'h0);

      // Reset mid-WAIT with two entries; the abandoned request's ack is stale.
      do_reset();
      inst_ready = 1'b0;
      run(4);
      ack_delay = 2;
      cyc();
      rst = 1'b1;
      cyc();
      check("midrst_valid", last_valid, 0);
      rst       = 1'b0;
      ack_delay = 1;
      cyc();
      check("midrst_req", last_req, 1);
      check("midrst_addr", last_addr, RESET_PC);
      inst_ready = 1'b1;
      popped.delete();
      run(8);
      check("midrst_pops", popped.size() >= 2, 1);
      check("midrst_pc0", popped[0], RESET_PC);
      check("midrst_pc1", popped[1], RESET_PC + 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
